// File: rtl/mul_sweep_checker.sv
// Exhaustive sweep checker for an external W x W unsigned multiplier: drives every
// operand pair, compares the returned product and reports errors. Optional fail map: MUL_SWEEP_FAIL_MAP_EN.
module mul_sweep_checker #(
    parameter int unsigned W      = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [W-1:0]         a_out,
    output logic [W-1:0]         b_out,
    input  logic [2*W-1:0]       p_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*W:0]         err_count,
    output logic                 ff_valid,
    output logic [W-1:0]         ff_a,
    output logic [W-1:0]         ff_b,
    output logic [2*W-1:0]       ff_p
`ifdef MUL_SWEEP_FAIL_MAP_EN
    ,
    output logic [(1<<(2*W))-1:0] fail_map
`endif
);

    localparam int unsigned IW = 2 * W;
    localparam int unsigned CW = 2 * W + 1;
    localparam int unsigned NV = 1 << IW;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state, state_d;
    logic [IW-1:0] idx, idx_d;
    logic [3:0]    cnt, cnt_d;
    logic [W-1:0]  a_d, b_d, ff_a_d, ff_b_d;
    logic [IW-1:0] ff_p_d;
    logic [CW-1:0] err_d;
    logic          busy_d, done_d, pass_d, ff_valid_d;
    logic          mismatch_c;
`ifdef MUL_SWEEP_FAIL_MAP_EN
    logic [NV-1:0] fail_map_d;
`endif

    // Operands are held in registers, so the reference product is taken from them directly
    assign mismatch_c = (p_in != (IW'(a_out) * IW'(b_out)));

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        cnt_d      = cnt;
        a_d        = a_out;
        b_d        = b_out;
        busy_d     = busy;
        done_d     = done;
        pass_d     = pass;
        err_d      = err_count;
        ff_valid_d = ff_valid;
        ff_a_d     = ff_a;
        ff_b_d     = ff_b;
        ff_p_d     = ff_p;
`ifdef MUL_SWEEP_FAIL_MAP_EN
        fail_map_d = fail_map;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = DRIVE;
                    idx_d      = '0;
                    cnt_d      = '0;
                    a_d        = '0;
                    b_d        = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    err_d      = '0;
                    ff_valid_d = 1'b0;
                    ff_a_d     = '0;
                    ff_b_d     = '0;
                    ff_p_d     = '0;
`ifdef MUL_SWEEP_FAIL_MAP_EN
                    fail_map_d = '0;
`endif
                end
            end
            DRIVE: begin
                if (cnt == 4'(SETTLE - 1)) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            CHECK: begin
                if (mismatch_c) begin
                    err_d = err_count + CW'(1);
`ifdef MUL_SWEEP_FAIL_MAP_EN
                    fail_map_d[idx] = 1'b1;
`endif
                    if (!ff_valid) begin
                        ff_valid_d = 1'b1;
                        ff_a_d     = a_out;
                        ff_b_d     = b_out;
                        ff_p_d     = p_in;
                    end
                end
                if (idx == IW'(NV - 1)) begin
                    state_d = DONE;
                    a_d     = '0;
                    b_d     = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx + IW'(1);
                    cnt_d   = '0;
                    a_d     = idx_d[IW-1:W];
                    b_d     = idx_d[W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            a_out     <= '0;
            b_out     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            ff_valid  <= 1'b0;
            ff_a      <= '0;
            ff_b      <= '0;
            ff_p      <= '0;
`ifdef MUL_SWEEP_FAIL_MAP_EN
            fail_map  <= '0;
`endif
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            cnt       <= cnt_d;
            a_out     <= a_d;
            b_out     <= b_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_count <= err_d;
            ff_valid  <= ff_valid_d;
            ff_a      <= ff_a_d;
            ff_b      <= ff_b_d;
            ff_p      <= ff_p_d;
`ifdef MUL_SWEEP_FAIL_MAP_EN
            fail_map  <= fail_map_d;
`endif
        end
    end

endmodule

// File: tb/tb_mul_sweep_checker.sv
// Directed self-checking bench for mul_sweep_checker (W=2, SETTLE=1 and SETTLE=3 instances).
module tb_mul_sweep_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start3;
    logic [1:0] a_out, b_out, a3, b3;
    logic [3:0] p_in, p3;
    logic       busy, done, pass, busy3, done3, pass3;
    logic [4:0] err_count, err3;
    logic       ff_valid, ff_valid3;
    logic [1:0] ff_a, ff_b, ff_a3, ff_b3;
    logic [3:0] ff_p, ff_p3;
`ifdef MUL_SWEEP_FAIL_MAP_EN
    logic [15:0] fail_map, fail_map3;
`endif

    int mode;
    int total  = 0;
    int passed = 0;
    int cyc;

    always #5 clk = ~clk;

    // Multiplier model: 0 correct, 1 stuck at zero, 2 wrong only for 3*2
    always_comb begin
        p_in = 4'(a_out) * 4'(b_out);
        if (mode == 1) p_in = 4'd0;
        if (mode == 2 && a_out == 2'd3 && b_out == 2'd2) p_in = 4'd0;
    end
    assign p3 = 4'(a3) * 4'(b3);

    mul_sweep_checker #(.W(2), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .a_out(a_out), .b_out(b_out), .p_in(p_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .ff_valid(ff_valid),
        .ff_a(ff_a), .ff_b(ff_b), .ff_p(ff_p)
`ifdef MUL_SWEEP_FAIL_MAP_EN
        , .fail_map(fail_map)
`endif
    );

    mul_sweep_checker #(.W(2), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a_out(a3), .b_out(b3), .p_in(p3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .ff_valid(ff_valid3),
        .ff_a(ff_a3), .ff_b(ff_b3), .ff_p(ff_p3)
`ifdef MUL_SWEEP_FAIL_MAP_EN
        , .fail_map(fail_map3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, optionally re-pulse at cycle repulse_at, and count cycles until done
    task automatic sweep(input int repulse_at, output int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_cleared", 32'(done), 32'd0);
        n = 0;
        while (!done && n < 200) begin
            if (n == repulse_at) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ab"}, {30'd0, a_out} | {30'd0, b_out}, 32'd0);
        check({tag, "_flags"}, {28'd0, busy, done, pass, ff_valid}, 32'd0);
        check({tag, "_err"}, 32'(err_count), 32'd0);
        check({tag, "_ff"}, {24'd0, ff_a, ff_b, ff_p}, 32'd0);
`ifdef MUL_SWEEP_FAIL_MAP_EN
        check({tag, "_map"}, 32'(fail_map), 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start3 = 1'b0; mode = 0;
        tick(); tick();
        rst = 1'b0;
        check_zero("reset");

        // Correct multiplier
        sweep(-1, cyc);
        check("ok_cycles", 32'(cyc), 32'd32);
        check("ok_pass", 32'(pass), 32'd1);
        check("ok_err", 32'(err_count), 32'd0);
        check("ok_ffv", 32'(ff_valid), 32'd0);
        check("ok_busy", 32'(busy), 32'd0);

        // Stuck-at-zero product; restart from DONE
        mode = 1;
        sweep(-1, cyc);
        check("s0_cycles", 32'(cyc), 32'd32);
        check("s0_err", 32'(err_count), 32'd9);
        check("s0_ff", {24'd0, ff_valid, ff_a, ff_b, ff_p}, {24'd0, 1'b1, 2'd1, 2'd1, 4'd0});
        check("s0_pass", 32'(pass), 32'd0);
`ifdef MUL_SWEEP_FAIL_MAP_EN
        check("s0_map", 32'(fail_map), 32'h0000EEE0);
`endif
        tick(); tick(); tick();
        check("s0_hold_err", 32'(err_count), 32'd9);
        check("s0_hold_done", {30'd0, done, pass}, 32'd2);
        check("s0_hold_ab", {28'd0, a_out, b_out}, 32'd0);

        // Single faulty vector 3*2
        mode = 2;
        sweep(-1, cyc);
        check("f32_err", 32'(err_count), 32'd1);
        check("f32_ff", {24'd0, ff_valid, ff_a, ff_b, ff_p}, {24'd0, 1'b1, 2'd3, 2'd2, 4'd0});
        check("f32_pass", 32'(pass), 32'd0);
`ifdef MUL_SWEEP_FAIL_MAP_EN
        check("f32_map", 32'(fail_map), 32'h00004000);
`endif

        // Reset 10 cycles into a failing sweep
        mode = 1;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check_zero("midrst");
        mode = 0;
        sweep(-1, cyc);
        check("post_rst_cycles", 32'(cyc), 32'd32);
        check("post_rst_pass", 32'(pass), 32'd1);

        // Start re-pulsed at cycle 5 is ignored; sample vector 2 in CHECK there
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            if (cyc == 5) begin
                check("mid_ab", {28'd0, a_out, b_out}, {28'd0, 2'd0, 2'd2});
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        check("repulse_cycles", 32'(cyc), 32'd32);
        check("repulse_pass", 32'(pass), 32'd1);

        // SETTLE=3: each vector held 4 cycles
        start3 = 1'b1; tick(); start3 = 1'b0;
        cyc = 0;
        while (!done3 && cyc < 400) begin
            if (cyc == 3) check("s3_b_c3", 32'(b3), 32'd0);
            if (cyc == 4) check("s3_b_c4", 32'(b3), 32'd1);
            if (cyc == 7) check("s3_b_c7", 32'(b3), 32'd1);
            if (cyc == 8) check("s3_b_c8", 32'(b3), 32'd2);
            tick();
            cyc++;
        end
        check("s3_cycles", 32'(cyc), 32'd64);
        check("s3_pass", 32'(pass3), 32'd1);
        check("s3_err", 32'(err3), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
